jam_cost_server: RTL and testbench

JAM_COST_SERVER -- requirements
Module: jam_cost_server

---
 rtl/jam_pkg.sv | 11 +
 rtl/jam_frame_chk.sv | 87 ++++++++
 rtl/jam_cost_server.sv | 68 ++++++
 tb/tb_jam_cost_server.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// jam_pkg: shared constants and state encoding for the jam cost server
package jam_pkg;
  localparam int N_W = 8;
  localparam int TBL_DEPTH = 64;
  localparam logic [9:0] REF_MIN_RST = 10'd1023;
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/jam_frame_chk.sv
// jam_frame_chk: audits Req frames (W sequence, unique J, cost sum) and tracks count, minimum and ties
module jam_frame_chk
  import jam_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic        req,
  input  logic [2:0]  w,
  input  logic [2:0]  j,
  input  logic [6:0]  cost,
  input  logic        valid,
  output logic [15:0] frame_count,
  output logic [9:0]  ref_min,
  output logic [3:0]  ref_match,
  output logic        err
);
  localparam logic [2:0] LAST_W = 3'(N_W - 1);
  logic       open_q, open_d, ferr_q, ferr_d, bad;
  logic [7:0] bm_q, bm_d;
  logic [9:0] sum_q, sum_d, min_d;
  logic [2:0] pw_q, pw_d;
  logic [15:0] fc_d;
  logic [3:0] match_d;
  always_comb begin
    open_d = open_q;
    bm_d = bm_q;
    sum_d = sum_q;
    pw_d = pw_q;
    ferr_d = ferr_q;
    fc_d = frame_count;
    min_d = ref_min;
    match_d = ref_match;
    bad = 1'b0;
    if (en && req) begin
      if (w == 3'd0) begin
        bad = open_q;
        open_d = 1'b1;
        bm_d = 8'd1 << j;
        sum_d = {3'd0, cost};
        pw_d = w;
        ferr_d = 1'b0;
      end else if (!open_q) begin
        bad = 1'b1;
      end else begin
        bad = (w != pw_q + 3'd1) || bm_q[j];
        bm_d = bm_q | (8'd1 << j);
        sum_d = sum_q + {3'd0, cost};
        pw_d = w;
        ferr_d = ferr_q | bad;
        if (w == LAST_W) begin
          open_d = 1'b0;
          if (!ferr_d) begin
            fc_d = (&frame_count) ? frame_count : frame_count + 16'd1;
            min_d = (sum_d < ref_min) ? sum_d : ref_min;
            match_d = (sum_d < ref_min) ? 4'd1 : (sum_d == ref_min) ? ref_match + 4'd1 : ref_match;
          end
        end
      end
    end
    // a closing Req in the same cycle as Valid leaves no frame open, so it is not an error
    if (en && valid && open_d) bad = 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      open_q <= 1'b0;
      ferr_q <= 1'b0;
      bm_q <= '0;
      sum_q <= '0;
      pw_q <= '0;
      frame_count <= '0;
      ref_min <= REF_MIN_RST;
      ref_match <= '0;
      err <= 1'b0;
    end else begin
      open_q <= open_d;
      ferr_q <= ferr_d;
      bm_q <= bm_d;
      sum_q <= sum_d;
      pw_q <= pw_d;
      frame_count <= fc_d;
      ref_min <= min_d;
      ref_match <= match_d;
      err <= err | bad;
    end
  end
endmodule

// File: rtl/jam_cost_server.sv
// jam_cost_server: loads an 8x8 cost table, serves Cost for (W,J) with zero latency
// and audits the initiator's per-worker frames.
module jam_cost_server
  import jam_pkg::*;
#(
  parameter int N_W = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Load_valid,
  input  logic [6:0]  Load_data,
  output logic        Load_ready,
  input  logic        Req,
  input  logic [2:0]  W,
  input  logic [2:0]  J,
  output logic [6:0]  Cost,
  input  logic        Valid,
  output logic        Ready,
  output logic [15:0] FrameCount,
  output logic [9:0]  RefMin,
  output logic [3:0]  RefMatch,
  output logic        Err,
  output logic        Done
);
  localparam logic [5:0] LAST_PTR = 6'(N_W * N_W - 1);
  state_t state, state_d;
  logic [5:0] ptr;
  logic [6:0] tbl [TBL_DEPTH];
  logic load_fire, chk_en;
  assign load_fire = Load_valid && Load_ready;
  always_ff @(posedge CLK) begin
    if (RST) state <= LOAD;
    else state <= state_d;
  end
  always_comb begin
    state_d = (state == LOAD && load_fire && ptr == LAST_PTR) ? SERVE :
              (state == SERVE && Valid) ? DONE : state;
  end
  always_comb begin
    Load_ready = state == LOAD;
    Ready = state != LOAD;
    Done = state == DONE;
    chk_en = state == SERVE;
    Cost = Load_ready ? 7'd0 : tbl[{W, J}];
  end
  always_ff @(posedge CLK) begin
    if (RST) ptr <= '0;
    else if (load_fire) ptr <= ptr + 6'd1;
  end
  // table is deliberately unreset; Ready stays low until a full reload
  always_ff @(posedge CLK) begin
    if (load_fire) tbl[ptr] <= Load_data;
  end
  jam_frame_chk u_chk (
    .CLK(CLK),
    .RST(RST),
    .en(chk_en),
    .req(Req),
    .w(W),
    .j(J),
    .cost(Cost),
    .valid(Valid),
    .frame_count(FrameCount),
    .ref_min(RefMin),
    .ref_match(RefMatch),
    .err(Err)
  );
endmodule

// File: tb/tb_jam_cost_server.sv
// tb_jam_cost_server: scoreboard bench with a queue-based frame reference model
module tb_jam_cost_server;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Load_valid = 1'b0;
  logic [6:0]  Load_data = '0;
  logic        Load_ready;
  logic        Req = 1'b0;
  logic [2:0]  W = '0;
  logic [2:0]  J = '0;
  logic [6:0]  Cost;
  logic        Valid = 1'b0;
  logic        Ready;
  logic [15:0] FrameCount;
  logic [9:0]  RefMin;
  logic [3:0]  RefMatch;
  logic        Err;
  logic        Done;

  always #5 CLK = ~CLK;

  jam_cost_server #(.N_W(8)) dut (
    .CLK(CLK), .RST(RST), .Load_valid(Load_valid), .Load_data(Load_data),
    .Load_ready(Load_ready), .Req(Req), .W(W), .J(J), .Cost(Cost), .Valid(Valid),
    .Ready(Ready), .FrameCount(FrameCount), .RefMin(RefMin), .RefMatch(RefMatch),
    .Err(Err), .Done(Done)
  );

  typedef struct {int id; int exp;} stat_t;
  localparam int P_LOAD = 0, P_SERVE = 1, P_DONE = 2;
  string nm[8] = '{"load_ready", "ready", "frame_count", "ref_min", "ref_match", "err", "done", "cost_probe"};

  int cost_q[$];
  stat_t stat_q[$];
  int n_tests = 0, n_fail = 0;
  logic probe = 1'b0;

  int m_tbl[64];
  int src[64];
  int m_phase, m_ptr, m_fc, m_min, m_match;
  bit m_open, m_ferr, m_err;
  int m_js[$], m_cs[$];

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic int dut_val(int id);
    case (id)
      0: return int'(Load_ready);
      1: return int'(Ready);
      2: return int'(FrameCount);
      3: return int'(RefMin);
      4: return int'(RefMatch);
      5: return int'(Err);
      6: return int'(Done);
      default: return int'(Cost);
    endcase
  endfunction

  always @(negedge CLK) begin : monitor
    stat_t s;
    if (Req) begin
      if (cost_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL cost_unexpected: got %0d, expected no request", Cost);
      end else check("cost", int'(Cost), cost_q.pop_front());
    end
    if (probe) begin
      while (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        check(nm[s.id], dut_val(s.id), s.exp);
      end
    end
  end

  function automatic void m_reset();
    m_phase = P_LOAD;
    m_ptr = 0;
    m_open = 0;
    m_ferr = 0;
    m_err = 0;
    m_fc = 0;
    m_min = 1023;
    m_match = 0;
    m_js.delete();
    m_cs.delete();
  endfunction

  function automatic int m_cost(int w, int j);
    return (m_phase == P_LOAD) ? 0 : m_tbl[w * 8 + j];
  endfunction

  // frame rules: the k-th request of a frame must carry W==k and a J not yet used
  function automatic void m_req(int w, int j);
    bit bad;
    int sum;
    if (m_phase != P_SERVE) return;
    if (w == 0) begin
      if (m_open) m_err = 1;
      m_open = 1;
      m_ferr = 0;
      m_js.delete();
      m_cs.delete();
      m_js.push_back(j);
      m_cs.push_back(m_tbl[j]);
      return;
    end
    if (!m_open) begin
      m_err = 1;
      return;
    end
    bad = (w != m_js.size());
    foreach (m_js[i]) if (m_js[i] == j) bad = 1;
    if (bad) begin
      m_err = 1;
      m_ferr = 1;
    end
    m_js.push_back(j);
    m_cs.push_back(m_tbl[w * 8 + j]);
    if (w == 7) begin
      m_open = 0;
      if (!m_ferr) begin
        sum = 0;
        foreach (m_cs[i]) sum += m_cs[i];
        if (m_fc < 65535) m_fc++;
        if (sum < m_min) begin
          m_min = sum;
          m_match = 1;
        end else if (sum == m_min) m_match = (m_match + 1) % 16;
      end
    end
  endfunction

  function automatic void m_valid();
    if (m_phase != P_SERVE) return;
    if (m_open) m_err = 1;
    m_phase = P_DONE;
  endfunction

  function automatic void exp_stat(int id, int e);
    stat_t s;
    s.id = id;
    s.exp = e;
    stat_q.push_back(s);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1;
    Req = 0;
    Valid = 0;
    Load_valid = 0;
    tick();
    RST = 0;
    m_reset();
  endtask

  task automatic load(int n, bit stall);
    int k = 0, c = 0;
    while (k < n) begin
      if (stall && c % 3 == 2) Load_valid = 0;
      else begin
        Load_valid = 1;
        Load_data = 7'(src[m_ptr & 63]);
      end
      tick();
      if (Load_valid) begin
        if (m_phase == P_LOAD) begin
          m_tbl[m_ptr] = int'(Load_data);
          m_ptr++;
          if (m_ptr == 64) m_phase = P_SERVE;
        end
        k++;
      end
      c++;
    end
    Load_valid = 0;
  endtask

  task automatic req(int w, int j, bit v = 0);
    Req = 1;
    W = 3'(w);
    J = 3'(j);
    Valid = v;
    cost_q.push_back(m_cost(w, j));
    m_req(w, j);
    if (v) m_valid();
    tick();
    Req = 0;
    Valid = 0;
  endtask

  task automatic pulse_valid();
    Valid = 1;
    m_valid();
    tick();
    Valid = 0;
  endtask

  task automatic chk_status();
    exp_stat(0, (m_phase == P_LOAD) ? 1 : 0);
    exp_stat(1, (m_phase != P_LOAD) ? 1 : 0);
    exp_stat(2, m_fc);
    exp_stat(3, m_min);
    exp_stat(4, m_match);
    exp_stat(5, int'(m_err));
    exp_stat(6, (m_phase == P_DONE) ? 1 : 0);
    exp_stat(7, m_cost(int'(W), int'(J)));
    probe = 1;
    tick();
    probe = 0;
  endtask

  task automatic frame(input int js[8], int last_w = 7, bit v_last = 0);
    for (int w = 0; w <= last_w; w++) req(w, js[w], v_last && w == last_w);
  endtask

  function automatic void fill_sum_table();
    for (int k = 0; k < 64; k++) src[k] = k / 8 + k % 8;
  endfunction

  task automatic rand_frame();
    int js[8];
    int f, r, t;
    for (int i = 0; i < 8; i++) js[i] = i;
    for (int i = 7; i > 0; i--) begin
      r = $urandom_range(0, i);
      t = js[i];
      js[i] = js[r];
      js[r] = t;
    end
    f = $urandom_range(0, 11);
    if (f == 0) js[$urandom_range(1, 7)] = js[0];
    if (f == 3) req(2, js[2]);
    for (int w = 0; w < 8; w++) begin
      if (f == 1 && w == 3) continue;
      if (f == 2 && w == 5) req(0, js[0]);
      if (f == 4 && w == 5) break;
      if ($urandom_range(0, 3) == 0) tick();
      req(w, js[w]);
    end
  endtask

  task automatic rand_run(int maxv);
    int ident[8];
    do_reset();
    for (int k = 0; k < 64; k++) src[k] = $urandom_range(0, maxv);
    load(64, 1'($urandom_range(0, 1)));
    chk_status();
    for (int n = 0; n < 30; n++) begin
      rand_frame();
      if ($urandom_range(0, 1) == 0) chk_status();
    end
    for (int i = 0; i < 8; i++) ident[i] = i;
    frame(ident, 7, 1);
    chk_status();
    req(0, 1);
    chk_status();
  endtask

  initial begin
    int ident[8], rev[8], shft[8], dup[8];
    for (int i = 0; i < 8; i++) begin
      ident[i] = i;
      rev[i] = 7 - i;
      shft[i] = (i + 1) % 8;
      dup[i] = (i == 7) ? 6 : i;
    end
    m_reset();
    do_reset();
    chk_status();
    for (int k = 0; k < 64; k++) src[k] = k % 128;
    load(63, 1);
    chk_status();
    load(1, 1);
    W = 3'd3;
    J = 3'd5;
    chk_status();
    do_reset();
    fill_sum_table();
    load(64, 0);
    frame(ident);
    chk_status();
    do_reset();
    src[63] = 18;
    load(64, 0);
    frame(rev);
    chk_status();
    frame(shft);
    chk_status();
    frame(ident);
    chk_status();
    frame(dup);
    chk_status();
    frame(ident);
    chk_status();
    do_reset();
    fill_sum_table();
    load(64, 0);
    frame(ident, 4);
    pulse_valid();
    chk_status();
    frame(ident);
    chk_status();
    do_reset();
    load(30, 0);
    do_reset();
    pulse_valid();
    req(3, 5);
    chk_status();
    load(63, 0);
    chk_status();
    load(1, 0);
    chk_status();
    rand_run(127);
    rand_run(2);
    repeat (3) tick();
    check("cost_q_drain", cost_q.size(), 0);
    check("stat_q_drain", stat_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
